// File: rtl/zebra_stop_arbiter.sv
// Debounced zebra-crossing stop decision: sliding-window vote, hysteresis FSM, hold timer and
// stale-input watchdog. Optional stripe-count gating of votes via `ZEBRA_STRIPE_GATE_EN.
module zebra_stop_arbiter #(
    parameter int unsigned WINDOW       = 8,
    parameter int unsigned ON_THRESH    = 5,
    parameter int unsigned OFF_THRESH   = 2,
    parameter int unsigned HOLD_FRAMES  = 30,
    parameter int unsigned STALE_FRAMES = 4,
    parameter int unsigned MIN_STRIPES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       det_valid,
    input  logic       det_crossing,
    input  logic [7:0] det_stripes,
    input  logic       frame_sync,
    output logic       stop_out,
    output logic [3:0] vote_count,
    output logic [1:0] state_out,
    output logic       stale
);

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StStop  = 2'd1,
        StHold  = 2'd2
    } state_e;

    localparam logic [3:0] OnTh     = 4'(ON_THRESH);
    localparam logic [3:0] OffTh    = 4'(OFF_THRESH);
    localparam logic [3:0] StaleMax = 4'(STALE_FRAMES);
    localparam logic [7:0] HoldInit = 8'(HOLD_FRAMES);

    logic              fs_q;
    logic              frame_tick;
    logic              vote_bit;
    logic [WINDOW-1:0] hist_q, hist_d;
    logic [3:0]        vote_q, vote_d;
    logic [3:0]        stale_cnt_q, stale_cnt_d;
    logic              stale_q, stale_d;
    state_e            state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic              stop_q, stop_d;

`ifdef ZEBRA_STRIPE_GATE_EN
    assign vote_bit = det_crossing & (det_stripes >= 8'(MIN_STRIPES));
`else
    localparam logic [7:0] unused_min_stripes = 8'(MIN_STRIPES);
    logic unused_stripes;
    assign unused_stripes = ^det_stripes;
    assign vote_bit = det_crossing;
`endif

    // Falling edge of the active-low vertical sync marks a frame boundary.
    assign frame_tick = fs_q & ~frame_sync;

    function automatic logic [3:0] popcount(input logic [WINDOW-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < WINDOW; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Vote history and watchdog; a detector verdict always beats a coincident frame tick.
    always_comb begin
        hist_d      = hist_q;
        vote_d      = vote_q;
        stale_cnt_d = stale_cnt_q;
        stale_d     = stale_q;
        if (det_valid) begin
            hist_d      = {hist_q[WINDOW-2:0], vote_bit};
            vote_d      = popcount(hist_d);
            stale_cnt_d = '0;
            stale_d     = 1'b0;
        end else if (frame_tick) begin
            if (stale_cnt_q < StaleMax) begin
                stale_cnt_d = stale_cnt_q + 4'd1;
            end
            if (stale_cnt_d == StaleMax) begin
                hist_d  = '0;
                vote_d  = '0;
                stale_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            StClear: begin
                if (vote_q >= OnTh) state_d = StStop;
            end
            StStop: begin
                if (vote_q <= OffTh) begin
                    state_d = StHold;
                    hold_d  = HoldInit;
                end
            end
            StHold: begin
                if (vote_q >= OnTh) begin
                    state_d = StStop;
                end else if (frame_tick) begin
                    if (hold_q <= 8'd1) begin
                        hold_d  = '0;
                        state_d = StClear;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = StClear;
                hold_d  = '0;
            end
        endcase
        stop_d = (state_d == StStop) || (state_d == StHold);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_q        <= 1'b1;
            hist_q      <= '0;
            vote_q      <= '0;
            stale_cnt_q <= '0;
            stale_q     <= 1'b0;
            state_q     <= StClear;
            hold_q      <= '0;
            stop_q      <= 1'b0;
        end else begin
            fs_q        <= frame_sync;
            hist_q      <= hist_d;
            vote_q      <= vote_d;
            stale_cnt_q <= stale_cnt_d;
            stale_q     <= stale_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            stop_q      <= stop_d;
        end
    end

    assign stop_out   = stop_q;
    assign vote_count = vote_q;
    assign state_out  = state_q;
    assign stale      = stale_q;

endmodule

// File: doc/zebra_stop_arbiter.md
Name: zebra_stop_arbiter

Overview:
- Downstream of pattern_recognition, in the clk_video domain.
- Consumes the per-frame crossing verdict (crossing_detected, detection_valid, stripe_count) and turns it into a debounced zebra stop decision.
- Uses sliding-window frame voting, hysteresis thresholds, a hold timer and a stale-input watchdog.
- Drives zebra_pattern_stop and the LEDG status bits in place of the raw AND of crossing_detected and detection_valid.

Parameters:
- WINDOW, 8: frames in the vote history, legal 2..15.
- ON_THRESH, 5: vote_count at or above this enters STOP.
- OFF_THRESH, 2: vote_count at or below this leaves STOP. Constraint: OFF_THRESH < ON_THRESH <= WINDOW.
- HOLD_FRAMES, 30: frame ticks stop_out is held after votes drop, legal 1..255.
- STALE_FRAMES, 4: frame ticks with no det_valid before the history is flushed, legal 1..15.
- MIN_STRIPES, 3: minimum stripe_count for a positive vote. Used only with the optional feature.

Ports:
- clk  in  1  clk_video.
- rst  in  1  Asynchronous, active-high reset.
- det_valid  in  1  One-cycle pulse, once per frame, from detection_valid.
- det_crossing  in  1  crossing_detected, qualified by det_valid.
- det_stripes  in  8  stripe_count, qualified by det_valid.
- frame_sync  in  1  VGA_VS, active-low, synchronous to clk.
- stop_out  out  1  Debounced stop decision.
- vote_count  out  4  Number of positive votes in the history.
- state_out  out  2  FSM state: 0 CLEAR, 1 STOP, 2 HOLD.
- stale  out  1  Detector silent for STALE_FRAMES ticks.

Behaviour:
- Reset values (async, immediate): stop_out=0, vote_count=0, state_out=0 (CLEAR), stale=0, history=0, hold counter=0, stale counter=0, frame_sync edge register=1.
- Frame tick: one-cycle internal pulse on a frame_sync 1->0 transition (previous sample 1, current sample 0).
- Vote bit = det_crossing (see Optional Feature).
- On a cycle with det_valid=1:
  - history shifts left and the vote bit enters bit 0; the oldest bit drops.
  - vote_count is registered as the popcount of the new history, visible the cycle after det_valid.
  - stale counter clears and stale deasserts.
- Stale watchdog:
  - Each frame tick without det_valid increments the stale counter (saturating).
  - When it reaches STALE_FRAMES: history and vote_count clear to 0 and stale=1 on that edge.
  - stale stays 1 until the next det_valid.
  - If det_valid and a frame tick coincide, det_valid wins: the counter clears and the tick is not counted.
- FSM evaluates the registered vote_count, so stop_out changes 2 cycles after the det_valid that caused it.
  - CLEAR: stop_out=0. If vote_count >= ON_THRESH, go to STOP.
  - STOP: stop_out=1. If vote_count <= OFF_THRESH, load hold counter = HOLD_FRAMES and go to HOLD.
  - HOLD: stop_out=1.
    - If vote_count >= ON_THRESH, go to STOP; the counter is not decremented that cycle.
    - Else on a frame tick, decrement the counter; a tick that takes it 1->0 goes to CLEAR on that same edge.
    - Stale flush while in HOLD: stay in HOLD and keep counting.
- stop_out and state_out are registered and change together.
- Unused encoding 3: recover to CLEAR with stop_out=0 on the next edge.
- det_valid while in HOLD does not affect the hold counter, except through the ON_THRESH re-entry.

Optional Feature:
- Macro: ZEBRA_STRIPE_GATE_EN.
- When defined: vote bit = det_crossing AND (det_stripes >= MIN_STRIPES), compared as unsigned 8-bit.
- When undefined: vote bit = det_crossing, det_stripes is ignored, and MIN_STRIPES has no effect.

Test Plan:
- Reset: assert rst mid-STOP with vote_count=6 -> stop_out=0, vote_count=0, state_out=0 and stale=0 immediately (without waiting for a clock edge); stay there after release with no stimulus.
- Entry: 5 det_valid pulses with crossing=1, spaced 100 cycles -> vote_count steps 1..5; stop_out=1 and state_out=1 exactly 2 cycles after the 5th pulse.
- Exit to hold:
  - From 5 ones, feed crossing=0 frames -> vote_count stays 5,5,5, then 4,3,2; state_out=2 after the 6th zero.
  - Then 30 frame ticks with det_valid alongside -> stop_out stays 1 through tick 29; state_out=0 and stop_out=0 on tick 30.
- Re-entry: in HOLD with the counter at 12, feed crossing=1 until vote_count=5 -> state_out=1, stop_out stays 1 with no glitch; hold counter reloads 30 on the next exit.
- Stale: in STOP, 4 frame ticks with no det_valid -> on tick 4 stale=1 and vote_count=0, state_out=2 one cycle later; the next det_valid with crossing=1 -> stale=0, vote_count=1.
- Stripe gate, with ZEBRA_STRIPE_GATE_EN: crossing=1, stripes=2 -> vote_count unchanged; stripes=3 -> +1. Without the macro: both add +1.
